// File: rtl/s_avg_scheduler.sv
// s_avg_scheduler: block averaging for CHANNELS oscilloscope inputs through one shared
// accumulate/round datapath. Per-channel averages leave on a valid/ready stream
// in ascending channel order.
module s_avg_scheduler #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 24,
    parameter int MAX_LOG2 = 24
) (
    input  logic                        nReset,
    input  logic                        Clk,
    input  logic                        Cfg_Valid,
    output logic                        Cfg_Ready,
    input  logic [4:0]                  Cfg_Log2N,
    input  logic [CHANNELS-1:0]         Cfg_Enable,
    input  logic                        In_Strobe,
    input  logic [CHANNELS*WIDTH-1:0]   In_Data,
    output logic                        Out_Valid,
    input  logic                        Out_Ready,
    output logic [2:0]                  Out_Channel,
    output logic [WIDTH-1:0]            Out_Data,
    output logic                        Drop_In,
    output logic                        Drop_Out
);
    localparam int ACC = WIDTH + MAX_LOG2;
    localparam int IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADD} state_t;

    state_t                          r_state, w_state_nxt;
    logic [4:0]                      r_log2n;
    logic [CHANNELS-1:0]             r_mask;
    logic [MAX_LOG2-1:0]             r_count;
    logic [IW-1:0]                   r_idx;
    logic [CHANNELS-1:0][WIDTH-1:0]  r_sample;
    logic [CHANNELS-1:0][ACC-1:0]    r_acc;
    logic [CHANNELS-1:0][WIDTH-1:0]  r_stage;
    logic                            r_drop_in, r_drop_out;

    // emitter state
    logic                            r_ev;
    logic [CHANNELS-1:0]             r_emask;
    logic [IW-1:0]                   r_ech;
    logic [CHANNELS-1:0][WIDTH-1:0]  r_hold;

    logic                            w_cfg_acc, w_strobe_acc;
    logic                            w_idx_last, w_cnt_last, w_load;
    logic [4:0]                      w_cfg_log2n;
    logic [MAX_LOG2-1:0]             w_cnt_max;
    logic signed [ACC-1:0]           w_samp, w_sum, w_bias, w_biased, w_shift;
    logic [WIDTH-1:0]                w_res;
    logic [CHANNELS-1:0][WIDTH-1:0]  w_stage_nxt;
    logic [IW-1:0]                   w_first, w_next;
    logic                            w_has_next;

    assign w_cfg_acc    = Cfg_Valid & Cfg_Ready;
    assign w_strobe_acc = (r_state == S_WAIT) & In_Strobe & ~w_cfg_acc;
    assign w_cfg_log2n  = (Cfg_Log2N > 5'(MAX_LOG2)) ? 5'(MAX_LOG2) : Cfg_Log2N;
    assign w_idx_last   = (r_idx == IW'(CHANNELS - 1));
    // all-ones in the low Log2N bits: the last count of a block
    assign w_cnt_max    = ~({MAX_LOG2{1'b1}} << r_log2n);
    assign w_cnt_last   = (r_count == w_cnt_max);
    assign w_load       = (r_state == S_ADD) & w_idx_last & w_cnt_last;

    // Shared datapath: accumulate channel r_idx, then round and saturate the new sum.
    // The last channel's result is taken straight from this path on the load edge.
    always_comb begin
        w_samp   = {{MAX_LOG2{r_sample[r_idx][WIDTH-1]}}, r_sample[r_idx]};
        w_sum    = (r_count == '0) ? w_samp : ($signed(r_acc[r_idx]) + w_samp);
        w_bias   = (r_log2n != 5'd0) ? (ACC'(1) << (r_log2n - 5'd1)) : '0;
        w_biased = w_sum + w_bias;
        w_shift  = w_biased >>> r_log2n;
        if ((&w_shift[ACC-1:WIDTH-1]) | ~(|w_shift[ACC-1:WIDTH-1]))
            w_res = w_shift[WIDTH-1:0];
        else if (w_shift[ACC-1])
            w_res = {1'b1, {(WIDTH-1){1'b0}}};
        else
            w_res = {1'b0, {(WIDTH-1){1'b1}}};
        w_stage_nxt = r_stage;
        if (r_mask[r_idx])
            w_stage_nxt[r_idx] = w_res;
    end

    // Main FSM state register
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Main FSM next state; a config wins over a strobe in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        Cfg_Ready   = (r_state != S_ADD);
        case (r_state)
            S_IDLE: if (w_cfg_acc) w_state_nxt = (|Cfg_Enable) ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (w_cfg_acc)      w_state_nxt = (|Cfg_Enable) ? S_WAIT : S_IDLE;
                else if (In_Strobe) w_state_nxt = S_ADD;
            end
            S_ADD:  if (w_idx_last) w_state_nxt = S_WAIT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Configuration, sample capture, accumulation and drop flags
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_log2n    <= '0;
            r_mask     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_sample   <= '0;
            r_acc      <= '0;
            r_stage    <= '0;
            r_drop_in  <= 1'b0;
            r_drop_out <= 1'b0;
        end else if (w_cfg_acc) begin
            r_log2n    <= w_cfg_log2n;
            r_mask     <= Cfg_Enable;
            r_count    <= '0;
            r_acc      <= '0;
            r_drop_in  <= 1'b0;
            r_drop_out <= 1'b0;
        end else if (w_strobe_acc) begin
            r_sample <= In_Data;
            r_idx    <= '0;
        end else if (r_state == S_ADD) begin
            if (r_mask[r_idx])
                r_acc[r_idx] <= w_sum;
            if (w_cnt_last)
                r_stage <= w_stage_nxt;
            if (w_idx_last) begin
                r_idx   <= '0;
                r_count <= w_cnt_last ? '0 : (r_count + 1'b1);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
            if (In_Strobe)
                r_drop_in <= 1'b1;
            if (w_load & r_ev)
                r_drop_out <= 1'b1;
        end
    end

    // Emitter channel search: lowest enabled in the live mask, next above r_ech in the load mask
    always_comb begin
        w_first    = '0;
        w_next     = '0;
        w_has_next = 1'b0;
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (r_mask[j])
                w_first = IW'(j);
            if (r_emask[j] && (IW'(j) > r_ech)) begin
                w_next     = IW'(j);
                w_has_next = 1'b1;
            end
        end
    end

    // Emitter: load results when idle, otherwise walk the enabled channels on each accept
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_ev    <= 1'b0;
            r_emask <= '0;
            r_ech   <= '0;
            r_hold  <= '0;
        end else if (w_load && !r_ev) begin
            r_hold  <= w_stage_nxt;
            r_emask <= r_mask;
            r_ech   <= w_first;
            r_ev    <= 1'b1;
        end else if (r_ev && Out_Ready) begin
            if (w_has_next) r_ech <= w_next;
            else            r_ev  <= 1'b0;
        end
    end

    assign Out_Valid   = r_ev;
    assign Out_Channel = 3'(r_ech);
    assign Out_Data    = r_hold[r_ech];
    assign Drop_In     = r_drop_in;
    assign Drop_Out    = r_drop_out;

endmodule

// File: tb/tb_s_avg_scheduler.sv
// Scoreboard bench for s_avg_scheduler: a plain-arithmetic block-average model pushes
// expected beats; a negedge monitor pops and compares whenever Out_Valid is high.
module tb_s_avg_scheduler;
    localparam int C  = 4;
    localparam int W  = 24;
    localparam int ML = 24;

    logic           nReset = 1'b0;
    logic           Clk = 1'b0;
    logic           Cfg_Valid = 1'b0;
    logic           Cfg_Ready;
    logic [4:0]     Cfg_Log2N = '0;
    logic [C-1:0]   Cfg_Enable = '0;
    logic           In_Strobe = 1'b0;
    logic [C*W-1:0] In_Data = '0;
    logic           Out_Valid;
    logic           Out_Ready = 1'b0;
    logic [2:0]     Out_Channel;
    logic [W-1:0]   Out_Data;
    logic           Drop_In, Drop_Out;

    s_avg_scheduler #(.CHANNELS(C), .WIDTH(W), .MAX_LOG2(ML)) dut (
        .nReset(nReset), .Clk(Clk),
        .Cfg_Valid(Cfg_Valid), .Cfg_Ready(Cfg_Ready), .Cfg_Log2N(Cfg_Log2N), .Cfg_Enable(Cfg_Enable),
        .In_Strobe(In_Strobe), .In_Data(In_Data),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Channel(Out_Channel), .Out_Data(Out_Data),
        .Drop_In(Drop_In), .Drop_Out(Drop_Out)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    typedef struct { int edge_n; logic [C-1:0] mask; logic [C-1:0][W-1:0] res; } load_t;
    typedef struct { logic [2:0] ch; logic [W-1:0] d; } beat_t;

    load_t  pend[$];
    beat_t  exp_q[$];
    int     n_cmp = 0, n_bad = 0;
    int     rdy_mode = 0;          // 0: ready high, 1: ready low, 2: random
    int     last_pop_edge = -10;
    longint m_sum[C];
    int     m_cnt, m_L, m_last_acc;
    logic [C-1:0] m_mask;
    logic   m_drop_in, m_drop_out;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Rounded average, half rounds toward +inf, floor division, saturated to W bits
    function automatic logic [W-1:0] ref_avg(input longint s, input int L);
        longint n, q, r, hi, lo;
        logic [63:0] rv;
        n  = longint'(1) << L;
        q  = s + n / 2;
        if (q >= 0) r = q / n;
        else        r = -((-q + n - 1) / n);
        hi = (longint'(1) << (W - 1)) - 1;
        lo = -(longint'(1) << (W - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        rv = r;
        return rv[W-1:0];
    endfunction

    function automatic logic [C*W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        logic [C*W-1:0] v;
        v = {W'(a3), W'(a2), W'(a1), W'(a0)};
        return v;
    endfunction

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        for (int i = 0; i < C; i++) m_sum[i] = 0;
        m_cnt = 0; m_L = 0; m_mask = '0; m_last_acc = -100;
        m_drop_in = 1'b0; m_drop_out = 1'b0; last_pop_edge = -10;
    endtask

    task automatic model_cfg(input int L, input logic [C-1:0] en);
        m_L = (L > ML) ? ML : L;
        m_mask = en;
        m_cnt = 0;
        for (int i = 0; i < C; i++) m_sum[i] = 0;
        m_drop_in = 1'b0; m_drop_out = 1'b0; m_last_acc = -100;
    endtask

    // A strobe at edge e is taken only when at least C+1 edges after the previous taken one
    task automatic model_strobe(input logic [C*W-1:0] d, input int e);
        load_t ld;
        if (m_mask == '0) return;
        if (e - m_last_acc <= C) begin
            m_drop_in = 1'b1;
            return;
        end
        m_last_acc = e;
        for (int i = 0; i < C; i++)
            if (m_mask[i]) m_sum[i] += longint'($signed(d[i*W +: W]));
        m_cnt++;
        if (m_cnt == (1 << m_L)) begin
            ld.edge_n = e + C;
            ld.mask   = m_mask;
            ld.res    = '0;
            for (int i = 0; i < C; i++) begin
                if (m_mask[i]) ld.res[i] = ref_avg(m_sum[i], m_L);
                m_sum[i] = 0;
            end
            m_cnt = 0;
            pend.push_back(ld);
        end
    endtask

    // Monitor: apply due loads, check valid against the queue, drive ready, compare beats
    always @(negedge Clk) begin : mon
        load_t ld;
        beat_t b;
        if (nReset) begin
            while (pend.size() > 0 && pend[0].edge_n <= cyc) begin
                ld = pend.pop_front();
                if (exp_q.size() > 0 || last_pop_edge == cyc) m_drop_out = 1'b1;
                else
                    for (int i = 0; i < C; i++)
                        if (ld.mask[i]) begin
                            b.ch = 3'(i);
                            b.d  = ld.res[i];
                            exp_q.push_back(b);
                        end
            end
            check("out_valid", longint'(Out_Valid), longint'(exp_q.size() > 0));
        end
        Out_Ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        if (nReset && Out_Valid && exp_q.size() > 0) begin
            check("out_channel", longint'(Out_Channel), longint'(exp_q[0].ch));
            check("out_data", longint'(Out_Data), longint'(exp_q[0].d));
            if (Out_Ready) begin
                void'(exp_q.pop_front());
                last_pop_edge = cyc + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_cfg(input int L, input logic [C-1:0] en);
        Cfg_Valid = 1'b1; Cfg_Log2N = 5'(L); Cfg_Enable = en;
        for (int t = 0; t < 100; t++) begin
            if (Cfg_Ready) begin
                model_cfg(L, en);
                @(negedge Clk);
                Cfg_Valid = 1'b0;
                return;
            end
            @(negedge Clk);
        end
        check("cfg_timeout", 0, 1);
        Cfg_Valid = 1'b0;
    endtask

    task automatic do_strobe(input logic [C*W-1:0] d, input int gap);
        In_Strobe = 1'b1; In_Data = d;
        model_strobe(d, cyc + 1);
        @(negedge Clk);
        In_Strobe = 1'b0;
        tick(gap - 1);
    endtask

    task automatic drain();
        int t;
        rdy_mode = 0;
        for (t = 0; t < 2000; t++) begin
            if (pend.size() == 0 && exp_q.size() == 0) break;
            @(negedge Clk);
        end
        if (t == 2000) check("drain_timeout", 0, 1);
        tick(C + 2);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_drop_in"}, longint'(Drop_In), longint'(m_drop_in));
        check({tag, "_drop_out"}, longint'(Drop_Out), longint'(m_drop_out));
    endtask

    // Called just after a negedge: assert reset, check outputs asynchronously, release
    task automatic do_reset();
        #2 nReset = 1'b0;
        #1;
        check("rst_cfg_ready", longint'(Cfg_Ready), 1);
        check("rst_out_valid", longint'(Out_Valid), 0);
        check("rst_out_channel", longint'(Out_Channel), 0);
        check("rst_out_data", longint'(Out_Data), 0);
        check("rst_drop_in", longint'(Drop_In), 0);
        check("rst_drop_out", longint'(Drop_Out), 0);
        model_reset();
        #1 nReset = 1'b1;
        @(negedge Clk);
    endtask

    initial begin : wdog
        #3000000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [C*W-1:0] d;
        int L, n;
        logic [C-1:0] en;
        model_reset();
        @(negedge Clk);
        do_reset();

        // two-channel averages with half-way rounding
        do_cfg(2, 4'b0101);
        for (int k = 0; k < 4; k++) do_strobe(pk(10 + k, 0, -1 - k, 0), 8);
        drain();
        check_flags("t1");

        // pass-through, four back-to-back beats
        do_cfg(0, 4'b1111);
        do_strobe(pk(100, 101, 102, 103), 6);
        drain();

        // strobe too close to the previous one is dropped
        do_cfg(1, 4'b0011);
        do_strobe(pk(7, -9, 0, 0), 2);
        do_strobe(pk(1000, 1000, 0, 0), 8);
        do_strobe(pk(4, -4, 0, 0), 8);
        drain();
        check_flags("t3");

        // output stalled across two blocks: second block discarded
        do_cfg(1, 4'b1010);
        rdy_mode = 1;
        for (int k = 0; k < 4; k++) do_strobe(pk(k * 3, -k * 7 - 1, k + 5, 8 - k), 6);
        tick(10);
        check_flags("t4");
        drain();

        // full-scale samples at minimum strobe spacing
        do_cfg(4, 4'b1111);
        for (int k = 0; k < 16; k++) do_strobe(pk(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF), C + 1);
        drain();
        for (int k = 0; k < 16; k++) do_strobe(pk(-8388608, -8388608, -8388608, -8388608), C + 1);
        drain();
        check_flags("t5");

        // reset in the middle of an ADD pass while a result is pending
        do_cfg(0, 4'b1111);
        rdy_mode = 1;
        do_strobe(pk(1, 2, 3, 4), 6);
        do_strobe(pk(5, 6, 7, 8), 1);
        check("pre_rst_valid", longint'(Out_Valid), 1);
        do_reset();
        rdy_mode = 0;
        do_cfg(1, 4'b0110);
        do_strobe(pk(0, 21, -5, 0), 5);
        do_strobe(pk(0, 2, -8, 0), 5);
        drain();
        check_flags("t6");

        // randomized blocks, spacing and back-pressure
        for (int p = 0; p < 8; p++) begin
            L  = $urandom_range(0, 3);
            en = 4'($urandom_range(1, 15));
            do_cfg(L, en);
            rdy_mode = $urandom_range(0, 2);
            n = (1 << L) * $urandom_range(2, 4) + $urandom_range(0, 1);
            for (int k = 0; k < n; k++) begin
                for (int i = 0; i < C; i++) d[i*W +: W] = W'($urandom);
                do_strobe(d, $urandom_range(1, 9));
            end
            drain();
            check_flags("rnd");
        end

        check("final_queue_empty", longint'(exp_q.size() + pend.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
